subservient_sram_bridge: RTL and testbench

- Parametrised successor to the single-byte SRAM wrapper.
- Shares one simple dual-port SRAM macro (separate read and write ports) between the serv register-file RAM interface and the 32-bit wishbone memory bus.
- SRAM data width is configurable (8/16/32), with per-byte write masks. The RF has absolute priority; wishbone accesses are serialised into beats on idle port cycles.
- Sits between the core's arbiter/rf_ram_if and the external SRAM pins.

---
 rtl/subservient_sram_pkg.sv | 23 ++
 rtl/subservient_sram_rdpipe.sv | 37 +++
 rtl/subservient_sram_bridge.sv | 152 +++++++++++++++
 tb/tb_subservient_sram_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subservient_sram_pkg.sv
// Shared FSM state type, read-latency constant and beat helper for the subservient SRAM bridge.
// SUBSERVIENT_SRAM_RDLAT2_EN selects a two-cycle (registered-output) SRAM read latency.
// No flow control of its own: constants and types only.
package subservient_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        ACK
    } state_t;

`ifdef SUBSERVIENT_SRAM_RDLAT2_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    function automatic int beats(input int dw);
        return 32 / dw;
    endfunction

endpackage

// File: rtl/subservient_sram_rdpipe.sv
// Valid+tag delay line matching the SRAM read latency so returning data can be steered to its slot.
// Latency: LAT cycles from push to pop.
// No backpressure: every push pops LAT cycles later unless flushed.
module subservient_sram_rdpipe #(
    parameter int LAT = 1,
    parameter int TW  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [TW-1:0] push_tag,
    output logic          pop_vld,
    output logic [TW-1:0] pop_tag
);

    logic [LAT-1:0] vld;
    logic [TW-1:0]  tag [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) tag[i] <= '0;
        end else begin
            vld[0] <= push_vld && !flush;
            tag[0] <= push_tag;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1] && !flush;
                tag[i] <= tag[i-1];
            end
        end
    end

    assign pop_vld = vld[LAT-1];
    assign pop_tag = tag[LAT-1];

endmodule

// File: rtl/subservient_sram_bridge.sv
// Shares one simple dual-port SRAM between the serv RF (absolute priority) and a 32-bit wishbone bus.
// Latency: RF read 1 cycle (2 with SUBSERVIENT_SRAM_RDLAT2_EN); wb write BEATS+1, wb read BEATS+1+RD_LAT.
// Backpressure: wishbone beats only use idle port cycles, so RF traffic delays the ack; RF never stalls.
module subservient_sram_bridge
    import subservient_sram_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int SRAM_DW = 8,
    parameter int SAW     = $clog2(DEPTH * 8 / SRAM_DW)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [SAW-1:0]            i_rf_waddr,
    input  logic [SRAM_DW-1:0]        i_rf_wdata,
    input  logic                      i_rf_wen,
    input  logic [SAW-1:0]            i_rf_raddr,
    input  logic                      i_rf_ren,
    output logic [SRAM_DW-1:0]        o_rf_rdata,
    input  logic [$clog2(DEPTH)-3:0]  i_wb_adr,
    input  logic [31:0]               i_wb_dat,
    input  logic [3:0]                i_wb_sel,
    input  logic                      i_wb_we,
    input  logic                      i_wb_stb,
    output logic [31:0]               o_wb_rdt,
    output logic                      o_wb_ack,
    output logic [SAW-1:0]            o_sram_waddr,
    output logic [SRAM_DW-1:0]        o_sram_wdata,
    output logic [SRAM_DW/8-1:0]      o_sram_wmask,
    output logic                      o_sram_wen,
    output logic [SAW-1:0]            o_sram_raddr,
    input  logic [SRAM_DW-1:0]        i_sram_rdata
);

    localparam int BEATS = beats(SRAM_DW);
    localparam int NB    = SRAM_DW / 8;
    localparam int AW    = $clog2(DEPTH) - 2;
    localparam int CW    = $clog2(BEATS);
    localparam int CNTW  = $clog2(BEATS + 1);
    localparam int TW    = (CW > 0) ? CW : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BEATS - 1);
    localparam logic [CNTW-1:0] CNT_END  = CNTW'(BEATS);
    localparam logic [TW-1:0]   TAG_LAST = TW'(BEATS - 1);

    state_t             state;
    logic [CNTW-1:0]    cnt;
    logic [AW-1:0]      adr_q;
    logic [31:0]        dat_q;
    logic [3:0]         sel_q;
    logic [SAW-1:0]     wb_addr;
    logic [SRAM_DW-1:0] wb_wdata;
    logic [NB-1:0]      wb_mask;
    logic               wr_go;
    logic               rd_go;
    logic               flush;
    logic               pop_vld;
    logic [TW-1:0]      pop_tag;

    // {adr, cnt} fills SAW exactly, so the beat address never wraps into the word address.
    assign wb_addr  = (SAW'(adr_q) << CW) | SAW'(cnt);
    assign wb_wdata = SRAM_DW'(dat_q >> (int'(cnt) * SRAM_DW));
    assign wb_mask  = NB'(sel_q >> (int'(cnt) * NB));

    assign wr_go = (state == WR) && i_wb_stb && !i_rf_wen;
    assign rd_go = (state == RD) && i_wb_stb && !i_rf_ren && (cnt < CNT_END);
    assign flush = (state == RD) && !i_wb_stb;

    always_comb begin
        o_sram_wen   = 1'b0;
        o_sram_waddr = '0;
        o_sram_wdata = '0;
        o_sram_wmask = '0;
        if (i_rf_wen) begin
            o_sram_wen   = 1'b1;
            o_sram_waddr = i_rf_waddr;
            o_sram_wdata = i_rf_wdata;
            o_sram_wmask = '1;
        end else if (wr_go) begin
            o_sram_wen   = |wb_mask;
            o_sram_waddr = wb_addr;
            o_sram_wdata = wb_wdata;
            o_sram_wmask = wb_mask;
        end
    end

    assign o_sram_raddr = i_rf_ren ? i_rf_raddr : (rd_go ? wb_addr : '0);
    assign o_rf_rdata   = i_sram_rdata;

    subservient_sram_rdpipe #(
        .LAT (RD_LAT),
        .TW  (TW)
    ) u_rdpipe (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (flush),
        .push_vld (rd_go),
        .push_tag (TW'(cnt)),
        .pop_vld  (pop_vld),
        .pop_tag  (pop_tag)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            // Beats return in issue order, so the last tag arriving means every slot is filled.
            if (pop_vld) o_wb_rdt[int'(pop_tag) * SRAM_DW +: SRAM_DW] <= i_sram_rdata;
            case (state)
                IDLE: begin
                    if (i_wb_stb && !o_wb_ack) begin
                        adr_q <= i_wb_adr;
                        dat_q <= i_wb_dat;
                        sel_q <= i_wb_sel;
                        cnt   <= '0;
                        state <= i_wb_we ? WR : RD;
                    end
                end
                WR: begin
                    if (!i_wb_stb) begin
                        state <= IDLE;
                    end else if (wr_go) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state    <= ACK;
                            o_wb_ack <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (!i_wb_stb) begin
                        state <= IDLE;
                    end else begin
                        if (rd_go) cnt <= cnt + 1'b1;
                        if (pop_vld && pop_tag == TAG_LAST) begin
                            state    <= ACK;
                            o_wb_ack <= 1'b1;
                        end
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subservient_sram_bridge.sv
// Directed bench for subservient_sram_bridge at SRAM_DW 8, 16 and 32, each with its own SRAM model.
module tb_subservient_sram_bridge;

`ifdef SUBSERVIENT_SRAM_RDLAT2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;

    // shared wishbone request fields, per-instance strobes
    logic [6:0]  w_adr;
    logic [31:0] w_dat;
    logic [3:0]  w_sel;
    logic        w_we;

    // 8-bit instance
    logic        a_stb, a_ack, a_rf_wen, a_rf_ren, a_sram_wen;
    logic [31:0] a_rdt;
    logic [8:0]  a_rf_waddr, a_rf_raddr, a_sram_waddr, a_sram_raddr;
    logic [7:0]  a_rf_wdata, a_rf_rdata, a_sram_wdata, a_sram_rdata, a_rd1, a_rd2;
    logic [0:0]  a_sram_wmask;
    logic [7:0]  mem_a [512];

    // 16-bit instance
    logic        b_stb, b_ack, b_rf_wen, b_rf_ren, b_sram_wen;
    logic [31:0] b_rdt;
    logic [7:0]  b_rf_waddr, b_rf_raddr, b_sram_waddr, b_sram_raddr;
    logic [15:0] b_rf_wdata, b_rf_rdata, b_sram_wdata, b_sram_rdata, b_rd1, b_rd2;
    logic [1:0]  b_sram_wmask;
    logic [15:0] mem_b [256];

    // 32-bit instance
    logic        c_stb, c_ack, c_rf_wen, c_rf_ren, c_sram_wen;
    logic [31:0] c_rdt;
    logic [6:0]  c_rf_waddr, c_rf_raddr, c_sram_waddr, c_sram_raddr;
    logic [31:0] c_rf_wdata, c_rf_rdata, c_sram_wdata, c_sram_rdata, c_rd1, c_rd2;
    logic [3:0]  c_sram_wmask;
    logic [31:0] mem_c [128];

    subservient_sram_bridge #(.DEPTH(512), .SRAM_DW(8)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rf_waddr(a_rf_waddr), .i_rf_wdata(a_rf_wdata), .i_rf_wen(a_rf_wen),
        .i_rf_raddr(a_rf_raddr), .i_rf_ren(a_rf_ren), .o_rf_rdata(a_rf_rdata),
        .i_wb_adr(w_adr), .i_wb_dat(w_dat), .i_wb_sel(w_sel), .i_wb_we(w_we), .i_wb_stb(a_stb),
        .o_wb_rdt(a_rdt), .o_wb_ack(a_ack),
        .o_sram_waddr(a_sram_waddr), .o_sram_wdata(a_sram_wdata), .o_sram_wmask(a_sram_wmask),
        .o_sram_wen(a_sram_wen), .o_sram_raddr(a_sram_raddr), .i_sram_rdata(a_sram_rdata)
    );

    subservient_sram_bridge #(.DEPTH(512), .SRAM_DW(16)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rf_waddr(b_rf_waddr), .i_rf_wdata(b_rf_wdata), .i_rf_wen(b_rf_wen),
        .i_rf_raddr(b_rf_raddr), .i_rf_ren(b_rf_ren), .o_rf_rdata(b_rf_rdata),
        .i_wb_adr(w_adr), .i_wb_dat(w_dat), .i_wb_sel(w_sel), .i_wb_we(w_we), .i_wb_stb(b_stb),
        .o_wb_rdt(b_rdt), .o_wb_ack(b_ack),
        .o_sram_waddr(b_sram_waddr), .o_sram_wdata(b_sram_wdata), .o_sram_wmask(b_sram_wmask),
        .o_sram_wen(b_sram_wen), .o_sram_raddr(b_sram_raddr), .i_sram_rdata(b_sram_rdata)
    );

    subservient_sram_bridge #(.DEPTH(512), .SRAM_DW(32)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rf_waddr(c_rf_waddr), .i_rf_wdata(c_rf_wdata), .i_rf_wen(c_rf_wen),
        .i_rf_raddr(c_rf_raddr), .i_rf_ren(c_rf_ren), .o_rf_rdata(c_rf_rdata),
        .i_wb_adr(w_adr), .i_wb_dat(w_dat), .i_wb_sel(w_sel), .i_wb_we(w_we), .i_wb_stb(c_stb),
        .o_wb_rdt(c_rdt), .o_wb_ack(c_ack),
        .o_sram_waddr(c_sram_waddr), .o_sram_wdata(c_sram_wdata), .o_sram_wmask(c_sram_wmask),
        .o_sram_wen(c_sram_wen), .o_sram_raddr(c_sram_raddr), .i_sram_rdata(c_sram_rdata)
    );

    // SRAM models: masked byte writes, read data LAT cycles after the address
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 512; i++) mem_a[i] <= '0;
        end else if (a_sram_wen && a_sram_wmask[0]) begin
            mem_a[a_sram_waddr] <= a_sram_wdata;
        end
        a_rd1 <= mem_a[a_sram_raddr];
        a_rd2 <= a_rd1;
    end
    assign a_sram_rdata = (LAT == 2) ? a_rd2 : a_rd1;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= '0;
        end else if (b_sram_wen) begin
            for (int j = 0; j < 2; j++)
                if (b_sram_wmask[j]) mem_b[b_sram_waddr][j*8 +: 8] <= b_sram_wdata[j*8 +: 8];
        end
        b_rd1 <= mem_b[b_sram_raddr];
        b_rd2 <= b_rd1;
    end
    assign b_sram_rdata = (LAT == 2) ? b_rd2 : b_rd1;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) mem_c[i] <= '0;
        end else if (c_sram_wen) begin
            for (int j = 0; j < 4; j++)
                if (c_sram_wmask[j]) mem_c[c_sram_waddr][j*8 +: 8] <= c_sram_wdata[j*8 +: 8];
        end
        c_rd1 <= mem_c[c_sram_raddr];
        c_rd2 <= c_rd1;
    end
    assign c_sram_rdata = (LAT == 2) ? c_rd2 : c_rd1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Samples each cycle from 'first' on; returns the first cycle with ack (-1 if none), then drops strobes.
    task automatic wait_ack(input int which, input int first, output int at);
        at = -1;
        for (int k = first; k < first + 20 && at < 0; k++) begin
            @(negedge clk);
            #1;
            if ((which == 0 && a_ack) || (which == 1 && b_ack) || (which == 2 && c_ack)) at = k;
        end
        a_stb = 1'b0;
        b_stb = 1'b0;
        c_stb = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; clr = 1'b1;
        w_adr = '0; w_dat = '0; w_sel = '0; w_we = 1'b0;
        a_stb = 0; a_rf_wen = 0; a_rf_ren = 0; a_rf_waddr = '0; a_rf_raddr = '0; a_rf_wdata = '0;
        b_stb = 0; b_rf_wen = 0; b_rf_ren = 0; b_rf_waddr = '0; b_rf_raddr = '0; b_rf_wdata = '0;
        c_stb = 0; c_rf_wen = 0; c_rf_ren = 0; c_rf_waddr = '0; c_rf_raddr = '0; c_rf_wdata = '0;

        @(negedge clk);
        #1;
        check("rst_ack", a_ack, 1'b0);
        check("rst_rdt", a_rdt, 32'h0);
        check("rst_wen", a_sram_wen, 1'b0);
        check("rst_wmask", a_sram_wmask, 1'b0);
        check("rst_waddr", a_sram_waddr, 9'h0);
        check("rst_raddr", a_sram_raddr, 9'h0);
        check("rst_ack_b", b_ack, 1'b0);
        check("rst_ack_c", c_ack, 1'b0);
        @(negedge clk);
        clr = 1'b0; rst_n = 1'b1;

        // 8-bit full write: bytes D4,C3,B2,A1 to 0x40..0x43, ack on cycle 5
        @(negedge clk);
        w_adr = 7'h10; w_dat = 32'hA1B2C3D4; w_sel = 4'hF; w_we = 1'b1; a_stb = 1'b1;
        #1;
        check("t1_c0_wen", a_sram_wen, 1'b0);
        d = 32'hA1B2C3D4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("t1_wen", a_sram_wen, 1'b1);
            check("t1_waddr", a_sram_waddr, 9'h40 + k);
            check("t1_wdata", a_sram_wdata, (d >> (8 * k)) & 32'hFF);
            check("t1_wmask", a_sram_wmask, 1'b1);
            check("t1_no_early_ack", a_ack, 1'b0);
        end
        wait_ack(0, 5, cyc);
        check("t1_ack_cycle", cyc, 5);
        check("t1_ack_wen", a_sram_wen, 1'b0);
        @(negedge clk);
        #1;
        check("t1_single_ack", a_ack, 1'b0);
        check("t1_mem", {mem_a[67], mem_a[66], mem_a[65], mem_a[64]}, 32'hA1B2C3D4);

        // 8-bit sparse write sel=0x5 at 0x20, then read back
        @(negedge clk);
        w_adr = 7'h20; w_sel = 4'h5; w_we = 1'b1; a_stb = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check("t2_beat_wen", a_sram_wen, (k == 1 || k == 3) ? 1'b1 : 1'b0);
        end
        wait_ack(0, 5, cyc);
        check("t2_wr_ack_cycle", cyc, 5);
        @(negedge clk);
        w_we = 1'b0; a_stb = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check("t2_rd_raddr", a_sram_raddr, 9'h80 + k - 1);
        end
        wait_ack(0, 5, cyc);
        check("t2_rd_ack_cycle", cyc, 5 + LAT);
        check("t2_rd_rdt", a_rdt, 32'h00B200D4);

        // 16-bit: preload through the RF port, then read with RF holding the read port 3 cycles
        @(negedge clk);
        b_rf_wen = 1'b1; b_rf_waddr = 8'h0A; b_rf_wdata = 16'h1234;
        #1;
        check("t3_rf_wmask", b_sram_wmask, 2'b11);
        check("t3_rf_wen", b_sram_wen, 1'b1);
        @(negedge clk);
        b_rf_waddr = 8'h0B; b_rf_wdata = 16'hABCD;
        @(negedge clk);
        b_rf_waddr = 8'h33; b_rf_wdata = 16'h5A5A;
        @(negedge clk);
        b_rf_wen = 1'b0; w_adr = 7'h05; w_we = 1'b0; b_stb = 1'b1;
        #1;
        check("t3_c0_raddr", b_sram_raddr, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            b_rf_ren = 1'b1; b_rf_raddr = 8'h33;
            #1;
            check("t3_rf_owns_raddr", b_sram_raddr, 8'h33);
            if (k == 3) check("t3_rf_rdata", b_rf_rdata, 16'h5A5A);
        end
        @(negedge clk);
        b_rf_ren = 1'b0; b_rf_raddr = '0;
        #1;
        check("t3_beat0_raddr", b_sram_raddr, 8'h0A);
        @(negedge clk);
        #1;
        check("t3_beat1_raddr", b_sram_raddr, 8'h0B);
        wait_ack(1, 6, cyc);
        check("t3_ack_cycle", cyc, 6 + LAT);
        check("t3_rdt", b_rdt, 32'hABCD1234);

        // 32-bit: RF write takes the port in the cycle the wb beat wanted it
        @(negedge clk);
        w_adr = 7'h03; w_dat = 32'hDEADBEEF; w_sel = 4'h6; w_we = 1'b1; c_stb = 1'b1;
        #1;
        check("t4_c0_wen", c_sram_wen, 1'b0);
        @(negedge clk);
        c_rf_wen = 1'b1; c_rf_waddr = 7'h10; c_rf_wdata = 32'h11223344;
        #1;
        check("t4_rf_waddr", c_sram_waddr, 7'h10);
        check("t4_rf_wdata", c_sram_wdata, 32'h11223344);
        check("t4_rf_wmask", c_sram_wmask, 4'hF);
        @(negedge clk);
        c_rf_wen = 1'b0; c_rf_waddr = '0; c_rf_wdata = '0;
        #1;
        check("t4_wb_wen", c_sram_wen, 1'b1);
        check("t4_wb_waddr", c_sram_waddr, 7'h03);
        check("t4_wb_wdata", c_sram_wdata, 32'hDEADBEEF);
        check("t4_wb_wmask", c_sram_wmask, 4'h6);
        wait_ack(2, 3, cyc);
        check("t4_ack_cycle", cyc, 3);
        check("t4_mem_wb", mem_c[3], 32'h00ADBE00);
        @(negedge clk);
        c_rf_ren = 1'b1; c_rf_raddr = 7'h10;
        @(negedge clk);
        c_rf_ren = 1'b0; c_rf_raddr = '0;
        repeat (LAT - 1) @(negedge clk);
        #1;
        check("t4_rf_rdata", c_rf_rdata, 32'h11223344);

        // 8-bit read aborted after its first beat; the next read completes normally
        @(negedge clk);
        w_adr = 7'h10; w_we = 1'b0; a_stb = 1'b1;
        @(negedge clk);
        #1;
        check("t5_beat0_raddr", a_sram_raddr, 9'h40);
        @(negedge clk);
        a_stb = 1'b0;
        #1;
        check("t5_abort_raddr", a_sram_raddr, 9'h0);
        check("t5_abort_ack", a_ack, 1'b0);
        @(negedge clk);
        w_adr = 7'h20; a_stb = 1'b1;
        #1;
        check("t5_idle_raddr", a_sram_raddr, 9'h0);
        check("t5_idle_ack", a_ack, 1'b0);
        wait_ack(0, 4, cyc);
        check("t5_ack_cycle", cyc, 8 + LAT);
        check("t5_rdt", a_rdt, 32'h00B200D4);

        // reset asserted mid-write, then a fresh read
        @(negedge clk);
        w_adr = 7'h30; w_dat = 32'h55667788; w_sel = 4'hF; w_we = 1'b1; a_stb = 1'b1;
        @(negedge clk);
        #1;
        check("t6_beat0_wdata", a_sram_wdata, 8'h88);
        @(negedge clk);
        #1;
        check("t6_beat1_waddr", a_sram_waddr, 9'hC1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wen", a_sram_wen, 1'b0);
        check("t6_rst_waddr", a_sram_waddr, 9'h0);
        check("t6_rst_wmask", a_sram_wmask, 1'b0);
        check("t6_rst_ack", a_ack, 1'b0);
        check("t6_rst_rdt", a_rdt, 32'h0);
        a_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w_adr = 7'h10; w_we = 1'b0; a_stb = 1'b1;
        wait_ack(0, 1, cyc);
        check("t6_ack_cycle", cyc, 5 + LAT);
        check("t6_rdt", a_rdt, 32'hA1B2C3D4);
        check("t6_mem_beat0", mem_a[9'hC0], 8'h88);
        check("t6_mem_beat1", mem_a[9'hC1], 8'h00);

        // RF read data alignment: back-to-back reads of 0x41 then 0x40
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            a_rf_ren   = (j < 2) ? 1'b1 : 1'b0;
            a_rf_raddr = (j == 0) ? 9'h41 : ((j == 1) ? 9'h40 : 9'h0);
            #1;
            if (j == LAT) check("t7_rf_rdata_first", a_rf_rdata, 8'hC3);
            if (j == LAT + 1) check("t7_rf_rdata_second", a_rf_rdata, 8'hD4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
